biu_xfer_ctrl: RTL and testbench

Sequencer for the bus interface unit's 32-bit address (MAR) and data (MDR) registers, which have ld/oe/inc controls.

---
 rtl/biu_pkg.sv | 63 ++++++
 rtl/biu_xfer_ctrl_if.sv | 34 +++
 rtl/biu_beat_cnt.sv | 28 ++
 rtl/biu_xfer_ctrl.sv | 124 ++++++++++++
 tb/tb_biu_xfer_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/biu_pkg.sv
// Shared types and constants for the bus interface unit transfer sequencer.
// Optional timeout support is controlled by BIU_XFER_TIMEOUT_EN in biu_xfer_ctrl.
package biu_pkg;

  localparam int   DEF_LEN_W   = 4;
  localparam int   DEF_TMO_CYC = 64;
  localparam logic RW_READ     = 1'b0;
  localparam logic RW_WRITE    = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ACCESS = 3'd2,
    S_NEXT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic mar_ld;
    logic mar_inc;
    logic mar_oe;
    logic mdr_ld;
    logic mdr_oe;
    logic mem_rd;
    logic mem_wr;
    logic busy;
    logic done;
  } moore_t;

  // State-only part of the output decode; ACCESS-cycle handshake terms are added in the top.
  function automatic moore_t moore_outs(state_t s, logic rw);
    moore_t m;
    m = '0;
    case (s)
      S_LOAD: begin
        m.busy   = 1'b1;
        m.mar_ld = 1'b1;
        m.mdr_ld = (rw == RW_WRITE);
      end
      S_ACCESS: begin
        m.busy   = 1'b1;
        m.mar_oe = 1'b1;
        m.mem_rd = (rw == RW_READ);
        m.mem_wr = (rw == RW_WRITE);
        m.mdr_oe = (rw == RW_WRITE);
      end
      S_NEXT: begin
        m.busy    = 1'b1;
        m.mar_inc = 1'b1;
        m.mdr_ld  = (rw == RW_WRITE);
        m.mdr_oe  = (rw == RW_READ);
      end
      S_DONE: begin
        m.busy   = 1'b1;
        m.done   = 1'b1;
        m.mdr_oe = (rw == RW_READ);
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/biu_xfer_ctrl_if.sv
// Request/handshake bundle between the execution unit, memory and the transfer sequencer.
// Signal prefixes are written from the sequencer's point of view.
interface biu_xfer_ctrl_if #(parameter int LEN_W = biu_pkg::DEF_LEN_W);

  logic             i_start;
  logic             i_rw;
  logic [LEN_W-1:0] i_len;
  logic             i_mem_rdy;

  logic o_mar_ld;
  logic o_mar_inc;
  logic o_mar_oe;
  logic o_mdr_ld;
  logic o_mdr_oe;
  logic o_mem_rd;
  logic o_mem_wr;
  logic o_beat_ack;
  logic o_busy;
  logic o_done;
  logic o_err;

  modport master (
    output i_start, i_rw, i_len, i_mem_rdy,
    input  o_mar_ld, o_mar_inc, o_mar_oe, o_mdr_ld, o_mdr_oe,
           o_mem_rd, o_mem_wr, o_beat_ack, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_rw, i_len, i_mem_rdy,
    output o_mar_ld, o_mar_inc, o_mar_oe, o_mdr_ld, o_mdr_oe,
           o_mem_rd, o_mem_wr, o_beat_ack, o_busy, o_done, o_err
  );

endinterface

// File: rtl/biu_beat_cnt.sv
// Loadable down-counter with zero flag; load has priority over decrement.
// Used both for the remaining-beat count and the memory-wait timeout.
module biu_beat_cnt #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/biu_xfer_ctrl.sv
// MAR/MDR sequencer for single and burst memory transfers.
// Define BIU_XFER_TIMEOUT_EN to abort a beat after TMO_CYC cycles without mem_rdy.
module biu_xfer_ctrl
  import biu_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input logic             i_clk,
  input logic             i_rst,
  biu_xfer_ctrl_if.slave  bus
);

  state_t r_state;
  logic   r_rw;
  moore_t r_out;
  logic   w_cnt_zero;
  logic   w_in_access;
  logic   w_start_acc;

  assign w_in_access = (r_state == S_ACCESS);
  assign w_start_acc = (r_state == S_IDLE) && bus.i_start;

  biu_beat_cnt #(.W(LEN_W)) u_beat_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ld     (w_start_acc),
    .i_ld_val (bus.i_len),
    .i_dec    (r_state == S_NEXT),
    .o_zero   (w_cnt_zero)
  );

`ifdef BIU_XFER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC) + 1;
  logic w_tmo_zero;
  logic r_err;

  // Preloaded with TMO_CYC-1 so the TMO_CYC-th silent ACCESS cycle is the one that aborts.
  biu_beat_cnt #(.W(TMO_W)) u_tmo_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ld     ((r_state == S_LOAD) || (r_state == S_NEXT)),
    .i_ld_val (TMO_W'(TMO_CYC - 1)),
    .i_dec    (w_in_access && !bus.i_mem_rdy && !w_tmo_zero),
    .o_zero   (w_tmo_zero)
  );
`endif

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_rw    <= RW_READ;
      r_out   <= '0;
`ifdef BIU_XFER_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
    end else begin
`ifdef BIU_XFER_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_state <= S_LOAD;
            r_rw    <= bus.i_rw;
            r_out   <= moore_outs(S_LOAD, bus.i_rw);
          end
        end
        S_LOAD: begin
          r_state <= S_ACCESS;
          r_out   <= moore_outs(S_ACCESS, r_rw);
        end
        S_ACCESS: begin
          if (bus.i_mem_rdy) begin
            if (w_cnt_zero) begin
              r_state <= S_DONE;
              r_out   <= moore_outs(S_DONE, r_rw);
            end else begin
              r_state <= S_NEXT;
              r_out   <= moore_outs(S_NEXT, r_rw);
            end
          end
`ifdef BIU_XFER_TIMEOUT_EN
          else if (w_tmo_zero) begin
            r_state <= S_DONE;
            r_out   <= moore_outs(S_DONE, r_rw);
            r_err   <= 1'b1;
          end
`endif
        end
        S_NEXT: begin
          r_state <= S_ACCESS;
          r_out   <= moore_outs(S_ACCESS, r_rw);
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_out   <= moore_outs(S_IDLE, r_rw);
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= '0;
        end
      endcase
    end
  end

  assign bus.o_mar_ld   = r_out.mar_ld;
  assign bus.o_mar_inc  = r_out.mar_inc;
  assign bus.o_mar_oe   = r_out.mar_oe;
  assign bus.o_mdr_ld   = r_out.mdr_ld | (w_in_access && bus.i_mem_rdy && (r_rw == RW_READ));
  assign bus.o_mdr_oe   = r_out.mdr_oe;
  assign bus.o_mem_rd   = r_out.mem_rd;
  assign bus.o_mem_wr   = r_out.mem_wr;
  assign bus.o_beat_ack = w_in_access && bus.i_mem_rdy;
  assign bus.o_busy     = r_out.busy;
  assign bus.o_done     = r_out.done;
`ifdef BIU_XFER_TIMEOUT_EN
  assign bus.o_err      = r_err;
`else
  assign bus.o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_biu_xfer_ctrl.sv
// Testbench for biu_xfer_ctrl: per-cycle output traces from a transfer-level model.
// Builds with or without BIU_XFER_TIMEOUT_EN; the model follows the same macro.
module tb_biu_xfer_ctrl;
  import biu_pkg::*;

  localparam int LW  = 4;
  localparam int TMO = 8;
`ifdef BIU_XFER_TIMEOUT_EN
  localparam int TMO_LIMIT = TMO;
`else
  localparam int TMO_LIMIT = 1 << 30;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   waitPlan[16];

  biu_xfer_ctrl_if #(.LEN_W(LW)) bus();

  biu_xfer_ctrl #(.LEN_W(LW), .TMO_CYC(TMO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bit order: mar_ld mar_inc mar_oe mdr_ld mdr_oe mem_rd mem_wr beat_ack busy done err
  function automatic logic [10:0] observed();
    return {bus.o_mar_ld, bus.o_mar_inc, bus.o_mar_oe, bus.o_mdr_ld, bus.o_mdr_oe,
            bus.o_mem_rd, bus.o_mem_wr, bus.o_beat_ack, bus.o_busy, bus.o_done, bus.o_err};
  endfunction

  function automatic logic [10:0] vLoad(input bit rw);
    return {1'b1, 1'b0, 1'b0, rw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  function automatic logic [10:0] vAccess(input bit rw, input bit rdy);
    return {1'b0, 1'b0, 1'b1, rdy & ~rw, rw, ~rw, rw, rdy, 1'b1, 1'b0, 1'b0};
  endfunction

  function automatic logic [10:0] vNext(input bit rw);
    return {1'b0, 1'b1, 1'b0, rw, ~rw, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  function automatic logic [10:0] vDone(input bit rw, input bit err);
    return {1'b0, 1'b0, 1'b0, 1'b0, ~rw, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, err};
  endfunction

  // One transfer from the IDLE cycle that raises start through its DONE cycle.
  task automatic run_xfer(input bit rw, input int len, input bit holdStart, input string name);
    logic [10:0] expq[$];
    bit          rdyq[$];
    logic [10:0] obs;
    bit          aborted = 0;
    int          expAcks = 0, sumWaits = 0;
    int          acks = 0, incs = 0, mdrLds = 0, doneAt = -1;

    expq.push_back(vLoad(rw));
    rdyq.push_back(1'b0);
    for (int b = 0; b <= len && !aborted; b++) begin
      if (waitPlan[b] >= TMO_LIMIT) begin
        for (int w = 0; w < TMO_LIMIT; w++) begin
          expq.push_back(vAccess(rw, 1'b0));
          rdyq.push_back(1'b0);
        end
        aborted = 1;
      end else begin
        sumWaits += waitPlan[b];
        for (int w = 0; w < waitPlan[b]; w++) begin
          expq.push_back(vAccess(rw, 1'b0));
          rdyq.push_back(1'b0);
        end
        expq.push_back(vAccess(rw, 1'b1));
        rdyq.push_back(1'b1);
        expAcks++;
        if (b < len) begin
          expq.push_back(vNext(rw));
          rdyq.push_back(1'b0);
        end
      end
    end
    expq.push_back(vDone(rw, aborted));
    rdyq.push_back(1'b0);

    @(posedge clk); #1;
    bus.i_start   = 1'b1;
    bus.i_rw      = rw;
    bus.i_len     = LW'(len);
    bus.i_mem_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== 11'b0) begin
      errors++;
      $display("FAIL %s idle outputs got=%b exp=%b", name, observed(), 11'b0);
    end

    for (int k = 0; k < expq.size(); k++) begin
      @(posedge clk); #1;
      bus.i_start   = holdStart;
      bus.i_rw      = ~rw;
      bus.i_len     = LW'($urandom);
      bus.i_mem_rdy = rdyq[k];
      @(negedge clk);
      obs = observed();
      acks   += obs[3];
      incs   += obs[9];
      mdrLds += obs[7];
      if (obs[1] && doneAt < 0) doneAt = k;
      checks++;
      if (obs !== expq[k]) begin
        errors++;
        $display("FAIL %s cyc%0d outputs got=%b exp=%b", name, k + 1, obs, expq[k]);
      end
    end
    bus.i_mem_rdy = 1'b0;

    checks++;
    if (acks != expAcks) begin
      errors++;
      $display("FAIL %s beat_ack count got=%0d exp=%0d", name, acks, expAcks);
    end
    if (!aborted) begin
      checks++;
      if (incs != len || mdrLds != len + 1) begin
        errors++;
        $display("FAIL %s inc/mdr_ld counts got=%0d/%0d exp=%0d/%0d", name, incs, mdrLds, len, len + 1);
      end
      checks++;
      if (doneAt + 1 != 2 * (len + 1) + 1 + sumWaits) begin
        errors++;
        $display("FAIL %s done cycle got=%0d exp=%0d", name, doneAt + 1, 2 * (len + 1) + 1 + sumWaits);
      end
    end
  endtask

  task automatic test_reset();
    bus.i_start = 1'b0; bus.i_rw = 1'b0; bus.i_len = '0; bus.i_mem_rdy = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (observed() !== 11'b0) begin
      errors++;
      $display("FAIL reset outputs got=%b exp=%b", observed(), 11'b0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    for (int i = 0; i < 16; i++) waitPlan[i] = 0;
    waitPlan[0] = 1;
    run_xfer(1'b0, 0, 1'b0, "single_read");
  endtask

  task automatic test_write_burst();
    for (int i = 0; i < 16; i++) waitPlan[i] = 0;
    run_xfer(1'b1, 3, 1'b0, "write_burst");
  endtask

  task automatic test_max_burst();
    for (int i = 0; i < 16; i++) waitPlan[i] = 0;
    run_xfer(1'b0, 15, 1'b0, "max_burst_rd");
    run_xfer(1'b1, 15, 1'b0, "max_burst_wr");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 16; i++) waitPlan[i] = $urandom_range(0, 3);
      run_xfer(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'b0, $sformatf("random%0d", n));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) waitPlan[i] = $urandom_range(0, 2);
    run_xfer(1'b1, 2, 1'b1, "b2b_first");
    run_xfer(1'b0, 1, 1'b1, "b2b_second");
    run_xfer(1'b1, 0, 1'b0, "b2b_third");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_rw = 1'b0; bus.i_len = LW'(3); bus.i_mem_rdy = 1'b0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    bus.i_mem_rdy = 1'b1;
    #1;
    checks++;
    if (observed() !== vAccess(1'b0, 1'b1)) begin
      errors++;
      $display("FAIL rst_mid pre-reset got=%b exp=%b", observed(), vAccess(1'b0, 1'b1));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (observed() !== 11'b0) begin
      errors++;
      $display("FAIL rst_mid async outputs got=%b exp=%b", observed(), 11'b0);
    end
    bus.i_mem_rdy = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (observed() !== 11'b0) begin
      errors++;
      $display("FAIL rst_mid held outputs got=%b exp=%b", observed(), 11'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) waitPlan[i] = 0;
    run_xfer(1'b0, 3, 1'b0, "after_reset");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 16; i++) waitPlan[i] = 0;
    waitPlan[0] = 110;
    run_xfer(1'b0, 0, 1'b0, "stall_read");
    waitPlan[0] = 1;
    waitPlan[1] = 12;
    run_xfer(1'b1, 2, 1'b0, "stall_write");
  endtask

  task automatic test_idle_after();
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== 11'b0) begin
      errors++;
      $display("FAIL idle_after outputs got=%b exp=%b", observed(), 11'b0);
    end
  endtask

  initial begin
    $display("[TB] starting biu_xfer_ctrl bench");
    test_reset();
    test_single_read();
    test_write_burst();
    test_max_burst();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    test_idle_after();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
